cdb_arbiter: RTL
================

# cdb_arbiter

Shares the 3-wide common data bus among the functional-unit completion ports. Each requester gets a one-entry holding buffer. Each cycle the block grants up to 3 pending results in round-robin order and drives registered broadcasts to the RS tag-match logic (`CDB_T_PACKET`), the PRF and the ROB. It sits between the FU output stage and the CDB consumers, and supplies the per-FU back-pressure that keeps completed results from being lost.

## Interface
- `NUM_REQ`, default 8: number of completion requesters (ALU_1..3, MULT_1..2, LS_1..2, BRANCH).
- `CDB_W`, default 3: broadcast slots per cycle.
- `TAG_W`, default `` `PR ``: physical register tag width.
- `DATA_W`, default `` `XLEN ``: result width.
- `clock`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `flush`, in, 1: squash (branch mispredict). Drops all held and incoming results.
- `req_valid`, in, NUM_REQ: FU i presents a result this cycle.
- `req_tag`, in, NUM_REQ×TAG_W: destination tag per requester.
- `req_data`, in, NUM_REQ×DATA_W: result value per requester.
- `req_ready`, out, NUM_REQ: requester i may present a result. Equals `~buf_valid[i]`; registered-state only.
- `cdb_valid`, out, CDB_W: slot k carries a broadcast.
- `cdb_tag`, out, CDB_W×TAG_W: broadcast tag per slot.
- `cdb_data`, out, CDB_W×DATA_W: broadcast value per slot.
- `cdb_src`, out, CDB_W×$clog2(NUM_REQ): index of the requester that owns slot k.
- `cdb_t`, out, CDB_T_PACKET: t0..t2 = `cdb_tag[k]` when `cdb_valid[k]`, else 0.

## Operation
- Candidate for requester i: the buffer if `buf_valid[i]`; else the incoming request if `req_valid[i] & req_ready[i]`.
- A request presented while `req_ready[i]=0` is ignored. The FU must hold it; the arbiter never overwrites its buffer.
- Arbitration scans indices `rr_ptr, rr_ptr+1, … (mod NUM_REQ)`. The first CDB_W candidates found are granted to slots 0,1,2 in scan order.
- A granted candidate is written to the slot output registers.
- A granted buffer entry clears `buf_valid`.
- An ungranted incoming request is captured into the buffer (`buf_valid` set).
- An ungranted buffered entry is held unchanged.
- Pointer update:
  - at least one grant: `rr_ptr <= (last granted index + 1) mod NUM_REQ`;
  - no grant: `rr_ptr` unchanged.
- Slots beyond the grant count: `cdb_valid=0`, tag/data/src = 0.
- Tag 0 is not special-cased: it is granted and broadcast with `cdb_valid=1`.
- Duplicate tags are not checked.
- `flush`:
  - all buffers are cleared at the edge; incoming requests that cycle are dropped;
  - `cdb_valid` is 0 the next cycle;
  - `rr_ptr` is retained.
- `reset`:
  - `rr_ptr=0`;
  - all `buf_valid=0`;
  - all `cdb_*` outputs 0 and `cdb_t=0`;
  - `req_ready` all 1.
  - Takes priority over `flush` and over any in-flight request.

## Timing
- Latency: a result accepted in cycle t with no contention appears on the CDB in cycle t+1 (registered outputs).
- A loser in cycle t waits in its buffer. `req_ready[i]` drops in cycle t+1.
- A buffered entry granted in cycle t: `req_ready[i]=1` in cycle t+1, so the FU can present a new result that same cycle.
- An uncontended requester sustains 1 result/cycle and never uses its buffer.
- Starvation bound: a pending candidate is granted within `ceil((NUM_REQ-1)/CDB_W)+1` cycles, which is 4 cycles with the defaults.
- There is no combinational path from `req_*` to `req_ready` or to `cdb_*`.

## Structure
- Shared package (`sys_defs.svh`) holds:
  - `CDB_T_PACKET` (already present);
  - a new `CDB_PACKET` {valid, tag, data, src};
  - the FU index constants (ALU_1 … BRANCH), which define requester numbering.
- One sub-module, `rr_select`: a combinational rotating-priority picker that takes a candidate vector and `rr_ptr` and returns up to CDB_W one-hot grants plus the last granted index.
- Buffers, output registers and the pointer live in `cdb_arbiter`.

## Test plan
- Reset:
  - Stimulus: reset=1 for 2 cycles, `req_valid=8'hFF` presented.
  - Required: `cdb_valid=0`, `cdb_t=0`, `req_ready=8'hFF`, nothing captured after release.
- Single result:
  - Stimulus: req 2 valid, tag 5, data 32'hDEAD in cycle t.
  - Required: cycle t+1 slot0 valid, tag 5, data DEAD, src 2; `cdb_t.t0=5`, t1=t2=0; `rr_ptr=3`.
- Over-subscription:
  - Stimulus: all 8 requesters valid in one cycle, `rr_ptr=0`, tags 1..8.
  - Required, per cycle:
    - t+1: tags 1,2,3;
    - t+2: tags 4,5,6;
    - t+3: tags 7,8, slot2 invalid.
  - Required: `req_ready` is 0 for indices 3..7 at t+1; every buffer is empty after t+3.
- Wrap-around:
  - Stimulus: `rr_ptr=6`, requesters 0,1,6,7 valid.
  - Required: slots = 6,7,0; requester 1 buffered; broadcast next cycle on slot0; `rr_ptr=2`.
- Back-to-back throughput:
  - Stimulus: requester 0 alone valid for 5 consecutive cycles, tags 10..14.
  - Required: one broadcast per cycle with tags 10..14 in order; `req_ready[0]` stays 1.
- Flush mid-contention:
  - Stimulus: 6 pending results (3 buffered), `flush` pulsed one cycle.
  - Required: next cycle `cdb_valid=0`; all `req_ready=1`; no flushed tag ever broadcast.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: tag/data widths, requester numbering, broadcast packets.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

    // Physical register tag width and result width
    localparam int PR   = 6;
    localparam int XLEN = 32;

    // Completion requester numbering; this is also the arbitration order
    localparam int ALU_1  = 0;
    localparam int ALU_2  = 1;
    localparam int ALU_3  = 2;
    localparam int MULT_1 = 3;
    localparam int MULT_2 = 4;
    localparam int LS_1   = 5;
    localparam int LS_2   = 6;
    localparam int BRANCH = 7;

    localparam int NUM_FU    = 8;
    localparam int CDB_SLOTS = 3;
    localparam int SRC_W     = $clog2(NUM_FU);

    // Tags seen by the RS tag-match logic; zero when the slot is idle
    typedef struct packed {
        logic [PR-1:0] t0;
        logic [PR-1:0] t1;
        logic [PR-1:0] t2;
    } CDB_T_PACKET;

    // One broadcast slot as registered by the arbiter
    typedef struct packed {
        logic             valid;
        logic [PR-1:0]    tag;
        logic [XLEN-1:0]  data;
        logic [SRC_W-1:0] src;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Rotating-priority picker: up to CDB_W one-hot grants scanning from i_ptr upward.
// Latency: purely combinational.
// Backpressure: none; ungranted candidates are the caller's to hold.
module rr_select #(
    parameter  int NUM_REQ = 8,
    parameter  int CDB_W   = 3,
    localparam int IDX_W   = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(CDB_W + 1)
) (
    input  logic [NUM_REQ-1:0]            i_cand,
    input  logic [IDX_W-1:0]              i_ptr,
    output logic [CDB_W-1:0][NUM_REQ-1:0] o_grant,
    output logic [NUM_REQ-1:0]            o_grant_any,
    output logic                          o_any,
    output logic [IDX_W-1:0]              o_last
);

    // Walk the ring from the pointer, handing out slots in scan order
    always_comb begin
        logic [CNT_W-1:0] w_n;
        logic [IDX_W-1:0] w_idx;
        int               w_j;
        o_grant     = '0;
        o_grant_any = '0;
        o_last      = '0;
        w_n         = '0;
        w_idx       = '0;
        w_j         = 0;
        for (int s = 0; s < NUM_REQ; s++) begin
            w_j = int'(i_ptr) + s;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            w_idx = IDX_W'(w_j);
            if (i_cand[w_idx] && (w_n < CNT_W'(CDB_W))) begin
                o_grant[w_n][w_idx] = 1'b1;
                o_grant_any[w_idx]  = 1'b1;
                o_last              = w_idx;
                w_n                 = w_n + CNT_W'(1);
            end
        end
        o_any = |o_grant_any;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the CDB among FU completion ports with one holding buffer per requester.
// Latency: accepted result broadcast next cycle when uncontended (registered slots).
// Backpressure: req_ready[i] = ~buf_valid[i], from registered state only.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = NUM_FU,
    parameter  int CDB_W   = CDB_SLOTS,
    parameter  int TAG_W   = PR,
    parameter  int DATA_W  = XLEN,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_flush,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]    i_req_tag,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]               o_req_ready,
    output logic [CDB_W-1:0]                 o_cdb_valid,
    output logic [CDB_W-1:0][TAG_W-1:0]      o_cdb_tag,
    output logic [CDB_W-1:0][DATA_W-1:0]     o_cdb_data,
    output logic [CDB_W-1:0][IDX_W-1:0]      o_cdb_src,
    output CDB_T_PACKET                      o_cdb_t
);

    logic [NUM_REQ-1:0]              r_buf_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0]   r_buf_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0]  r_buf_data;
    logic [IDX_W-1:0]                r_rr_ptr;
    CDB_PACKET [CDB_W-1:0]           r_slot;

    logic [NUM_REQ-1:0]              w_accept;
    logic [NUM_REQ-1:0]              w_cand;
    logic [NUM_REQ-1:0][TAG_W-1:0]   w_cand_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0]  w_cand_data;
    logic [CDB_W-1:0][NUM_REQ-1:0]   w_grant;
    logic [NUM_REQ-1:0]              w_grant_any;
    logic                            w_any;
    logic [IDX_W-1:0]                w_last;
    logic [IDX_W-1:0]                w_ptr_nxt;
    CDB_PACKET [CDB_W-1:0]           w_slot;

    // A held entry always wins over a new request; requests seen while full are ignored
    always_comb begin
        w_accept = i_req_valid & ~r_buf_valid;
        w_cand   = r_buf_valid | w_accept;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand_tag[i]  = r_buf_valid[i] ? r_buf_tag[i]  : i_req_tag[i];
            w_cand_data[i] = r_buf_valid[i] ? r_buf_data[i] : i_req_data[i];
        end
    end

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .CDB_W   (CDB_W)
    ) u_rr_select (
        .i_cand      (w_cand),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_any (w_grant_any),
        .o_any       (w_any),
        .o_last      (w_last)
    );

    // Route each granted candidate onto its slot; idle slots stay all-zero
    always_comb begin
        for (int k = 0; k < CDB_W; k++) begin
            w_slot[k]       = '0;
            w_slot[k].valid = |w_grant[k];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[k][i]) begin
                    w_slot[k].tag  = w_cand_tag[i];
                    w_slot[k].data = w_cand_data[i];
                    w_slot[k].src  = IDX_W'(i);
                end
            end
        end
        w_ptr_nxt = (w_last == IDX_W'(NUM_REQ - 1)) ? '0 : w_last + IDX_W'(1);
    end

    // Buffers, broadcast slots and pointer; flush squashes everything but the pointer
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_buf_valid <= '0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
            r_rr_ptr    <= '0;
            r_slot      <= '0;
        end else if (i_flush) begin
            r_buf_valid <= '0;
            r_slot      <= '0;
        end else begin
            r_slot <= w_slot;
            if (w_any) r_rr_ptr <= w_ptr_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant_any[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end else if (w_accept[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_tag[i]   <= i_req_tag[i];
                    r_buf_data[i]  <= i_req_data[i];
                end
            end
        end
    end

    assign o_req_ready = ~r_buf_valid;

    // Unpack registered slots onto the broadcast ports
    always_comb begin
        for (int k = 0; k < CDB_W; k++) begin
            o_cdb_valid[k] = r_slot[k].valid;
            o_cdb_tag[k]   = r_slot[k].tag;
            o_cdb_data[k]  = r_slot[k].data;
            o_cdb_src[k]   = r_slot[k].src;
        end
        o_cdb_t    = '0;
        o_cdb_t.t0 = r_slot[0].valid ? r_slot[0].tag : '0;
        o_cdb_t.t1 = r_slot[1].valid ? r_slot[1].tag : '0;
        o_cdb_t.t2 = r_slot[2].valid ? r_slot[2].tag : '0;
    end

endmodule
